// File: rtl/io_op_sequencer_pkg.sv
// Shared types for the IO-board op sequencer: op/state enums, 7-seg digit
// patterns and the op evaluation helper.
package io_pkg;

  typedef enum logic [1:0] {OP_AND, OP_OR, OP_NAND, OP_NOR} op_e;
  typedef enum logic {ST_IDLE, ST_SHOW} state_e;

  localparam logic [6:0] SEG_DIG0 = 7'b1000000;
  localparam logic [6:0] SEG_DIG1 = 7'b1111001;
  localparam logic [6:0] SEG_DIG2 = 7'b0100100;
  localparam logic [6:0] SEG_DIG3 = 7'b0110000;

  function automatic logic [6:0] seg_digit(input op_e op);
    case (op)
      OP_AND:  return SEG_DIG0;
      OP_OR:   return SEG_DIG1;
      OP_NAND: return SEG_DIG2;
      default: return SEG_DIG3;
    endcase
  endfunction

  function automatic logic [3:0] op_eval(input op_e op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_NAND: return ~(a & b);
      default: return ~(a | b);
    endcase
  endfunction

endpackage

// File: rtl/io_op_sequencer_if.sv
// IO board pin bundle: buttons/switches in, LEDs and 7-seg out.
interface io_op_sequencer_if;
  logic [3:0] IO_PB;
  logic [7:0] IO_DSW;
  logic [7:0] IO_LED;
  logic [3:0] IO_SSEGD;
  logic [7:0] IO_SSEG;
  logic       IO_SSEG_COL;
  logic       DEC_POINT;

  modport master (output IO_PB, IO_DSW,
                  input  IO_LED, IO_SSEGD, IO_SSEG, IO_SSEG_COL, DEC_POINT);
  modport slave  (input  IO_PB, IO_DSW,
                  output IO_LED, IO_SSEGD, IO_SSEG, IO_SSEG_COL, DEC_POINT);
endinterface

// File: rtl/io_op_sequencer_pb_debounce.sv
// One pushbutton: 2-flop sync, stability counter, registered press pulse
// on a debounced 1->0 transition.
module pb_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pb_n,
  output logic o_press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    r_sync;
  logic          r_deb;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          w_diff;
  logic          w_done;

  assign w_diff  = r_sync[1] ^ r_deb;
  assign w_done  = w_diff && (r_cnt == CW'(DEB_CYCLES - 1));
  assign o_press = r_press;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= 2'b11;
      r_deb   <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_pb_n};
      // flipping while currently released means the new level is pressed
      r_press <= w_done & r_deb;
      if (w_done) begin
        r_deb <= r_sync[1];
        r_cnt <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/io_op_sequencer.sv
// Button-selected logic op on DIP operands, shown on LEDs and one 7-seg digit.
// Optional AUTO_CYCLE_EN: op auto-advances after AUTO_CYCLES idle cycles in SHOW.
module io_op_sequencer
  import io_pkg::*;
#(
  parameter int DEB_CYCLES  = 16,
  parameter int AUTO_CYCLES = 64
) (
  input logic          M_CLOCK,
  input logic          RESET,
  io_op_sequencer_if.slave io
);
  logic [1:0][7:0] r_dsw_sync;
  logic [3:0]      w_press;
  logic            w_evt;
  op_e             w_sel;
  state_e          r_state, w_state_nxt;
  op_e             r_op, w_op_nxt;
  logic [7:0]      r_led;
  logic [3:0]      r_ssegd;
  logic [7:0]      r_sseg;

  if (DEB_CYCLES < 1 || AUTO_CYCLES < 1) begin : g_param_chk
    $error("io_op_sequencer: DEB_CYCLES and AUTO_CYCLES must be >= 1");
  end

  for (genvar g = 0; g < 4; g++) begin : g_pb
    pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .i_clk  (M_CLOCK),
      .i_rst  (RESET),
      .i_pb_n (io.IO_PB[g]),
      .o_press(w_press[g])
    );
  end

  always_ff @(posedge M_CLOCK) begin
    if (RESET) r_dsw_sync <= '1;
    else       r_dsw_sync <= {r_dsw_sync[0], io.IO_DSW};
  end

  // fixed priority, PB0 wins; other simultaneous events are dropped
  always_comb begin
    w_evt = |w_press;
    w_sel = OP_AND;
    if      (w_press[0]) w_sel = OP_AND;
    else if (w_press[1]) w_sel = OP_OR;
    else if (w_press[2]) w_sel = OP_NAND;
    else if (w_press[3]) w_sel = OP_NOR;
  end

`ifdef AUTO_CYCLE_EN
  localparam int TW = $clog2(AUTO_CYCLES + 1);
  logic [TW-1:0] r_timer, w_timer_nxt;

  always_ff @(posedge M_CLOCK) begin
    if (RESET) r_timer <= '0;
    else       r_timer <= w_timer_nxt;
  end
`endif

  always_ff @(posedge M_CLOCK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_op    <= OP_AND;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
`ifdef AUTO_CYCLE_EN
    w_timer_nxt = '0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_evt) begin
          w_state_nxt = ST_SHOW;
          w_op_nxt    = w_sel;
        end
      end
      ST_SHOW: begin
        if (w_evt) begin
          if (w_sel == r_op) w_state_nxt = ST_IDLE;
          else               w_op_nxt    = w_sel;
        end
`ifdef AUTO_CYCLE_EN
        else if (r_timer == TW'(AUTO_CYCLES - 1)) w_op_nxt = op_e'(r_op + 2'd1);
        else w_timer_nxt = r_timer + TW'(1);
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge M_CLOCK) begin
    if (RESET || r_state == ST_IDLE) begin
      r_led   <= 8'h00;
      r_ssegd <= 4'b1111;
      r_sseg  <= 8'hFF;
    end else begin
      r_led   <= {4'(1) << r_op, op_eval(r_op, r_dsw_sync[1][7:4], r_dsw_sync[1][3:0])};
      r_ssegd <= 4'b1110;
      r_sseg  <= {1'b1, seg_digit(r_op)};
    end
  end

  assign io.IO_LED      = r_led;
  assign io.IO_SSEGD    = r_ssegd;
  assign io.IO_SSEG     = r_sseg;
  assign io.IO_SSEG_COL = 1'b1;
  assign io.DEC_POINT   = 1'b1;
endmodule

// File: tb/tb_io_op_sequencer.sv
// Scoreboard bench: stimulus pushes expected output changes with due cycle,
// a negedge monitor pops and compares on every observed output change.
module tb_io_op_sequencer;
  localparam int DEB  = 4;
  localparam int AUTO = 20;
  localparam int LAT  = DEB + 4;

  typedef struct {
    string      name;
    logic [7:0] led;
    logic [3:0] ssegd;
    logic [7:0] sseg;
    int         due;
    bit         exact;
  } exp_t;

  logic M_CLOCK = 1'b0;
  logic RESET;
  io_op_sequencer_if bus();

  io_op_sequencer #(.DEB_CYCLES(DEB), .AUTO_CYCLES(AUTO)) dut (
    .M_CLOCK(M_CLOCK),
    .RESET  (RESET),
    .io     (bus)
  );

  always #5 M_CLOCK = ~M_CLOCK;

  int cyc = 0;
  always @(posedge M_CLOCK) cyc <= cyc + 1;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [19:0] last;
  logic [19:0] cur;
  exp_t        e;

  always @(negedge M_CLOCK) begin
    if (mon_en) begin
      cur = {bus.IO_LED, bus.IO_SSEGD, bus.IO_SSEG};
      if (cur !== last) begin
        last = cur;
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change @%0d: got led=%h ssegd=%b sseg=%h, required no change",
                   cyc, bus.IO_LED, bus.IO_SSEGD, bus.IO_SSEG);
        end else begin
          e = sb.pop_front();
          if (cur !== {e.led, e.ssegd, e.sseg}) begin
            n_fail++;
            $display("FAIL %s value: got led=%h ssegd=%b sseg=%h, required led=%h ssegd=%b sseg=%h",
                     e.name, bus.IO_LED, bus.IO_SSEGD, bus.IO_SSEG, e.led, e.ssegd, e.sseg);
          end
          if (e.exact) begin
            n_chk++;
            if (cyc != e.due) begin
              n_fail++;
              $display("FAIL %s latency: changed at cycle %0d, required cycle %0d", e.name, cyc, e.due);
            end
          end
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        e = sb.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL %s timeout: no output change by cycle %0d, required led=%h", e.name, e.due, e.led);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge M_CLOCK);
  endtask

  task automatic expect_out(input string nm, input logic [7:0] led, input logic [3:0] sd,
                            input logic [7:0] sg, input int due, input bit exact);
    exp_t x;
    x.name = nm; x.led = led; x.ssegd = sd; x.sseg = sg; x.due = due; x.exact = exact;
    sb.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // press the masked buttons cleanly, hold, release and let the release settle
  task automatic press(input logic [3:0] mask, input string nm, input logic [7:0] led,
                       input logic [3:0] sd, input logic [7:0] sg);
    int c;
    c = cyc;
    bus.IO_PB = ~mask;
    expect_out(nm, led, sd, sg, c + LAT, 1'b1);
    tick(10);
    bus.IO_PB = 4'hF;
    tick(7);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    RESET      = 1'b1;
    bus.IO_PB  = 4'hF;
    bus.IO_DSW = 8'hC5;
    tick(3);
    RESET = 1'b0;
    tick(1);
    chk("reset_led",   bus.IO_LED, 8'h00);
    chk("reset_ssegd", {4'h0, bus.IO_SSEGD}, 8'h0F);
    chk("reset_sseg",  bus.IO_SSEG, 8'hFF);
    chk("sseg_col",    {7'h0, bus.IO_SSEG_COL}, 8'h01);
    chk("dec_point",   {7'h0, bus.DEC_POINT}, 8'h01);
    last   = {bus.IO_LED, bus.IO_SSEGD, bus.IO_SSEG};
    mon_en = 1'b1;
    tick(5);

    press(4'b0001, "pb0_and", 8'h14, 4'b1110, 8'hC0);
    press(4'b0001, "pb0_off", 8'h00, 4'b1111, 8'hFF);

    for (int i = 0; i < 12; i++) begin
      bus.IO_PB[1] = ((i % 4) < 2) ? 1'b0 : 1'b1;
      tick(1);
    end
    press(4'b0010, "pb1_bounce_or", 8'h2D, 4'b1110, 8'hF9);

    press(4'b1100, "pb23_nand", 8'h4B, 4'b1110, 8'hA4);
    press(4'b0100, "pb2_off", 8'h00, 4'b1111, 8'hFF);

    bus.IO_DSW = 8'h00;
    tick(4);
    c = cyc;
    press(4'b1000, "pb3_nor", 8'h8F, 4'b1110, 8'hB0);
    bus.IO_DSW = 8'hFF;
    expect_out("dsw_change", 8'h80, 4'b1110, 8'hB0, cyc + 3, 1'b1);
`ifdef AUTO_CYCLE_EN
    expect_out("auto_wrap", 8'h1F, 4'b1110, 8'hC0, c + 28, 1'b1);
    while (cyc < c + 29) tick(1);
`else
    while (cyc < c + 50) tick(1);
    chk("hold_nor_led",  bus.IO_LED, 8'h80);
    chk("hold_nor_sseg", bus.IO_SSEG, 8'hB0);
`endif

    c = cyc;
    bus.IO_PB[0] = 1'b0;
    tick(3);
    RESET = 1'b1;
    expect_out("mid_debounce_reset", 8'h00, 4'b1111, 8'hFF, c + 4, 1'b1);
    tick(1);
    RESET = 1'b0;
    expect_out("post_reset_press", 8'h1F, 4'b1110, 8'hC0, c + 12, 1'b1);
    tick(12);
    bus.IO_PB = 4'hF;
    tick(7);

    for (int i = 0; i < 60 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
